// File: rtl/dummy_pattern_gen.sv
// dummy_pattern_gen: finite-burst stimulus source on a valid/ready stream.
//   On start it sends len_i words. Each word is either an incrementing count
//   or a 32-bit Galois LFSR value copied into each 32-bit lane, with the lane
//   index XORed in.
//
// Ports
//   clk_i, reset_i      rising-edge clock, synchronous active-high reset
//   start_i             request a burst (taken in IDLE only)
//   mode_i/len_i/seed_i pattern select, word count, LFSR seed (latched with start_i)
//   data_o, valid_o     stream output, held stable while stalled
//   ready_i             sink ready
//   busy_o              high while words are being sent
//   done_o              one-cycle pulse at burst end
//   words_sent_o        words accepted in the current or most recent burst
//   err_inj_i           only when DUMMY_PATGEN_ERRINJ_EN is defined: flips
//                       data_o[0] of the next transferred word
//
// Optional feature macro: DUMMY_PATGEN_ERRINJ_EN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; outputs quiet, words_sent_o holds
// SEND  | presenting words; advances on valid_o & ready_i
// DONE  | one-cycle done_o pulse, start_i ignored
module dummy_pattern_gen #(
  parameter int          DATA_W = 128,
  parameter int          LEN_W  = 16,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [31:0]       seed_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
`ifdef DUMMY_PATGEN_ERRINJ_EN
  input  logic              err_inj_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  words_sent_o
);

  localparam logic [31:0] POLY  = 32'h8020_0003;
  localparam int          LANES = DATA_W / 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q;
  logic [LEN_W-1:0]   remain_q;
  logic [LEN_W-1:0]   words_sent_q;
  logic [31:0]        lfsr_q;
  logic               start_acc;
  logic               xfer;
  logic               last_word;
  logic [DATA_W-1:0]  pattern;

  assign start_acc = (state_q == IDLE) && start_i;
  assign xfer      = (state_q == SEND) && ready_i;
  // remain_q counts down the words still to send; the last word is the
  // one being transferred while the count reads 1.
  assign last_word = (remain_q == LEN_W'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        if (ready_i && last_word) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q       <= 1'b0;
      remain_q     <= '0;
      words_sent_q <= '0;
      lfsr_q       <= SEED;
    end else if (start_acc) begin
      mode_q       <= mode_i;
      remain_q     <= len_i;
      words_sent_q <= '0;
      lfsr_q       <= (seed_i == 32'd0) ? SEED : seed_i;
    end else if (xfer) begin
      remain_q     <= remain_q - LEN_W'(1);
      words_sent_q <= words_sent_q + LEN_W'(1);
      lfsr_q       <= lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    end
  end

  // The word index equals the number of words already accepted, so the
  // counter pattern is taken straight from words_sent_q.
  always_comb begin
    pattern = '0;
    if (mode_q) begin
      for (int i = 0; i < LANES; i++) begin
        pattern[i*32 +: 32] = lfsr_q ^ 32'(i);
      end
    end else begin
      pattern = DATA_W'(words_sent_q);
    end
  end

`ifdef DUMMY_PATGEN_ERRINJ_EN
  logic err_pend_q;

  // A new pulse takes priority over clearing on a transfer in the same
  // cycle, so that pulse applies to the following word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_pend_q <= 1'b0;
    end else if (state_q == DONE) begin
      err_pend_q <= 1'b0;
    end else if (err_inj_i) begin
      err_pend_q <= 1'b1;
    end else if (xfer) begin
      err_pend_q <= 1'b0;
    end
  end

  always_comb begin
    data_o = '0;
    if (state_q == SEND) begin
      data_o    = pattern;
      data_o[0] = pattern[0] ^ err_pend_q;
    end
  end
`else
  always_comb begin
    data_o = '0;
    if (state_q == SEND) begin
      data_o = pattern;
    end
  end
`endif

  assign words_sent_o = words_sent_q;

endmodule
